// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard query bundle: decoded instruction fields in, stall decision
// and stall statistics out.
interface hazard_scoreboard_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_W-1:0]  id_rd;
  logic              id_wr;
  logic [1:0]        id_class;
  logic              stall;
  logic [1:0]        stall_reason;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr, id_class,
    input  stall, stall_reason, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr, id_class,
    output stall, stall_reason, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard for the ID stage: stalls on RAW, WAW and
// MUL/DIV-busy hazards, reports the reason and counts stalled cycles.
module hazard_scoreboard #(
  parameter int REG_W      = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 4,
  parameter int PERF_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave id
);

  localparam int unsigned NREG   = 2 ** REG_W;
  localparam int          MAXLAT = (LOAD_LAT > MULDIV_LAT) ? LOAD_LAT : MULDIV_LAT;
  localparam int          CW     = $clog2(MAXLAT + 1);

  localparam logic [CW-1:0] LOAD_C   = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MULDIV_C = CW'(MULDIV_LAT);

  generate
    if (LOAD_LAT < 1 || MULDIV_LAT < 1) begin : g_bad_latency
      $error("hazard_scoreboard: LOAD_LAT and MULDIV_LAT must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MDU  = 2'd2,
    CLS_RSVD = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    RSN_NONE = 2'd0,
    RSN_RAW  = 2'd1,
    RSN_WAW  = 2'd2,
    RSN_MDU  = 2'd3
  } reason_e;

  logic [CW-1:0]     cnt [NREG];
  logic [CW-1:0]     mdu_cnt;
  logic [PERF_W-1:0] perf_q;

  cls_e          cls;
  reason_e       reason;
  logic [CW-1:0] lat;
  logic          rs_hit;
  logic          rt_hit;
  logic          raw;
  logic          waw;
  logic          mdu;
  logic          stall_w;
  logic          issue;
  logic          set_dst;

  always_comb begin
    cls = cls_e'(id.id_class);
    lat = '0;
    case (cls)
      CLS_LOAD: lat = LOAD_C;
      CLS_MDU:  lat = MULDIV_C;
      default:  lat = '0;
    endcase
  end

  // Register 0 reads are filtered here; its counter is also never set.
  always_comb begin
    rs_hit  = id.id_use_rs && (id.id_rs != '0) && (cnt[id.id_rs] != '0);
    rt_hit  = id.id_use_rt && (id.id_rt != '0) && (cnt[id.id_rt] != '0);
    raw     = id.id_valid && (rs_hit || rt_hit);
    waw     = id.id_valid && id.id_wr && (id.id_rd != '0) && (cnt[id.id_rd] > lat);
    mdu     = id.id_valid && (cls == CLS_MDU) && (mdu_cnt != '0);
    stall_w = raw || waw || mdu;
    issue   = id.id_valid && !stall_w;
    set_dst = issue && id.id_wr && (id.id_rd != '0);
  end

  always_comb begin
    reason = RSN_NONE;
    if (raw)      reason = RSN_RAW;
    else if (waw) reason = RSN_WAW;
    else if (mdu) reason = RSN_MDU;
  end

  assign id.stall        = stall_w;
  assign id.stall_reason = reason;
  assign id.stall_cycles = perf_q;

  // Loading lat also covers the ALU case: lat=0 clears the entry on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r[REG_W-1:0]] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (cnt[r[REG_W-1:0]] != '0) begin
          cnt[r[REG_W-1:0]] <= cnt[r[REG_W-1:0]] - CW'(1);
        end
      end
      if (set_dst) begin
        cnt[id.id_rd] <= lat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
    end else if (issue && (cls == CLS_MDU)) begin
      mdu_cnt <= MULDIV_C;
    end else if (mdu_cnt != '0) begin
      mdu_cnt <= mdu_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (stall_w) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  a_reg0_untracked: assert property (@(posedge clk) cnt[0] == '0);

  a_issue_not_older: assert property (@(posedge clk) disable iff (!rst_n)
    set_dst |-> (cnt[id.id_rd] <= lat));

  a_stall_has_reason: assert property (@(posedge clk) disable iff (!rst_n)
    stall_w |-> (reason != RSN_NONE));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset/wrap sequences and
// random traffic against a timestamp-based readiness model.
module tb_hazard_scoreboard;

  localparam int REG_W      = 5;
  localparam int LOAD_LAT   = 1;
  localparam int MULDIV_LAT = 4;
  localparam int PERF_W     = 4;
  localparam int PERF_MOD   = 1 << PERF_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(REG_W), .PERF_W(PERF_W)) bus ();

  hazard_scoreboard #(
    .REG_W(REG_W),
    .LOAD_LAT(LOAD_LAT),
    .MULDIV_LAT(MULDIV_LAT),
    .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id(bus)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       wr;
    logic [1:0] cls;
    logic       es;
    logic [1:0] er;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Model: each register holds the cycle number from which it is readable.
  int now = 0;
  int ready [32];
  int mdu_ready = 0;
  int perf = 0;

  function automatic vec_t mk(input logic v, input int rs, input int rt,
                              input logic urs, input logic urt, input int rd,
                              input logic wr, input int cls, input logic es,
                              input int er);
    vec_t x;
    x.v = v; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt;
    x.rd = 5'(rd); x.wr = wr; x.cls = 2'(cls); x.es = es; x.er = 2'(er);
    return x;
  endfunction

  function automatic int rem(input int r);
    return (ready[r] > now) ? ready[r] - now : 0;
  endfunction

  function automatic int latof(input logic [1:0] c);
    if (c == 2'd1) return LOAD_LAT;
    if (c == 2'd2) return MULDIV_LAT;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ready[i] = 0;
    mdu_ready = 0;
    perf = 0;
  endtask

  task automatic model_eval(input vec_t x, output logic s, output logic [1:0] why);
    bit raw, waw, busy;
    raw  = x.v && ((x.urs && x.rs != 0 && rem(int'(x.rs)) > 0) ||
                   (x.urt && x.rt != 0 && rem(int'(x.rt)) > 0));
    waw  = x.v && x.wr && x.rd != 0 && rem(int'(x.rd)) > latof(x.cls);
    busy = x.v && x.cls == 2'd2 && mdu_ready > now;
    s = raw || waw || busy;
    why = raw ? 2'd1 : waw ? 2'd2 : busy ? 2'd3 : 2'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.id_valid  = x.v;
    bus.id_rs     = x.rs;
    bus.id_rt     = x.rt;
    bus.id_use_rs = x.urs;
    bus.id_use_rt = x.urt;
    bus.id_rd     = x.rd;
    bus.id_wr     = x.wr;
    bus.id_class  = x.cls;
  endtask

  // One ID cycle: drive after the edge, compare on the falling edge, commit model.
  task automatic step(input vec_t x, input bit use_tab, input string tag, output logic s);
    logic [1:0] why;
    drive(x);
    @(negedge clk);
    model_eval(x, s, why);
    chk($sformatf("%s stall", tag), 32'(bus.stall), 32'(s));
    chk($sformatf("%s reason", tag), 32'(bus.stall_reason), 32'(why));
    chk($sformatf("%s stall_cycles", tag), 32'(bus.stall_cycles), 32'(perf));
    if (use_tab) begin
      chk($sformatf("%s tab_stall", tag), 32'(bus.stall), 32'(x.es));
      chk($sformatf("%s tab_reason", tag), 32'(bus.stall_reason), 32'(x.er));
    end
    if (s) perf = (perf + 1) % PERF_MOD;
    if (x.v && !s) begin
      if (x.wr && x.rd != 0) ready[x.rd] = now + 1 + latof(x.cls);
      if (x.cls == 2'd2) mdu_ready = now + 1 + MULDIV_LAT;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  vec_t tab[$];
  vec_t x;
  logic s;
  int   stalls;
  int   guard;

  initial begin
    // Directed cycle-by-cycle table; expectations derived by hand.
    tab.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0));   // lw r8
    tab.push_back(mk(1, 8, 1, 1, 1, 9, 1, 0, 1, 1));   // add r9,r8,r1: load-use bubble
    tab.push_back(mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 0));
    tab.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1, 0, 0));   // lw r8
    tab.push_back(mk(1, 2, 8, 1, 0, 10, 1, 0, 0, 0));  // addi: rt=8 not read
    tab.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1, 0, 0));   // lw r8
    tab.push_back(mk(1, 0, 8, 1, 0, 0, 1, 1, 0, 0));   // lw r0 from r0
    tab.push_back(mk(1, 0, 0, 1, 1, 11, 1, 0, 0, 0));  // reads r0 only
    tab.push_back(mk(1, 1, 2, 1, 1, 3, 1, 2, 0, 0));   // mul r3
    for (int i = 0; i < MULDIV_LAT; i++)
      tab.push_back(mk(1, 3, 1, 1, 1, 5, 1, 0, 1, 1)); // consumer of r3
    tab.push_back(mk(1, 3, 1, 1, 1, 5, 1, 0, 0, 0));
    tab.push_back(mk(1, 1, 2, 1, 1, 6, 1, 2, 0, 0));   // mul r6
    for (int i = 0; i < MULDIV_LAT; i++)
      tab.push_back(mk(1, 1, 2, 1, 1, 7, 1, 2, 1, 3)); // mul r7: unit busy
    tab.push_back(mk(1, 1, 2, 1, 1, 7, 1, 2, 0, 0));
    tab.push_back(mk(1, 7, 0, 1, 0, 11, 1, 2, 1, 1));  // RAW + busy -> RAW
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(0, 7, 7, 1, 1, 7, 1, 2, 0, 0)); // bubbles
    tab.push_back(mk(1, 1, 2, 1, 1, 4, 1, 2, 0, 0));   // mul r4
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(1, 1, 0, 1, 0, 4, 1, 1, 1, 2)); // lw r4: WAW
    tab.push_back(mk(1, 1, 0, 1, 0, 4, 1, 1, 0, 0));
    tab.push_back(mk(1, 4, 0, 1, 0, 9, 1, 0, 1, 1));   // r4 left at 1
    tab.push_back(mk(1, 4, 0, 1, 0, 9, 1, 0, 0, 0));
    tab.push_back(mk(1, 12, 0, 1, 0, 12, 1, 1, 0, 0)); // lw r12,(r12)
    tab.push_back(mk(1, 12, 0, 1, 0, 12, 1, 0, 1, 1));
    tab.push_back(mk(1, 12, 0, 1, 0, 12, 1, 0, 0, 0));
    tab.push_back(mk(1, 12, 12, 1, 1, 13, 1, 0, 0, 0));
    tab.push_back(mk(1, 1, 2, 1, 1, 14, 1, 2, 0, 0));  // mul r14
    tab.push_back(mk(1, 1, 2, 1, 1, 14, 1, 3, 1, 2));  // reserved class: WAW

    drive(mk(1, 5, 5, 1, 1, 5, 1, 2, 0, 0));
    model_reset();
    #2;
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset reason", 32'(bus.stall_reason), 32'd0);
    chk("reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tab[i]) step(tab[i], 1'b1, $sformatf("vec%0d", i), s);

    // Async reset while r5 still has 3 cycles pending and a consumer is stalled.
    for (int i = 0; i < MULDIV_LAT + 1; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "idle", s);
    step(mk(1, 1, 2, 1, 1, 5, 1, 2, 0, 0), 1'b1, "mul_r5", s);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "gap", s);
    x = mk(1, 5, 0, 1, 0, 9, 1, 0, 1, 1);
    drive(x);
    @(negedge clk);
    chk("pre_reset stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset stall", 32'(bus.stall), 32'd0);
    chk("mid_reset reason", 32'(bus.stall_reason), 32'd0);
    chk("mid_reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    now++;
    rst_n = 1'b1;
    step(mk(1, 5, 0, 1, 0, 9, 1, 0, 0, 0), 1'b1, "post_reset", s);

    // Wrap: reset the counter, then accumulate 17 stalled cycles.
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    stalls = 0;
    guard = 0;
    while (stalls < 17 && guard < 200) begin
      step(mk(1, 3, 3, 1, 1, 3, 1, 2, 0, 0), 1'b0, "wrap_seq", s);
      if (s) stalls++;
      guard++;
    end
    chk("wrap budget", 32'(stalls), 32'd17);
    chk("wrap stall_cycles", 32'(bus.stall_cycles), 32'd1);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      x = mk(($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
             int'($urandom_range(0, 3)), 1'b0, 0);
      step(x, 1'b0, "rand", s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
